// File: rtl/counter_nbit.sv
// Prescaled up/down counter with a programmable terminal value, wrap or saturate
// behaviour, a registered terminal-count pulse, a compare match and a sticky overflow flag.
module counter_nbit #(
  parameter int WIDTH      = 8,
  parameter int PRESCALE_W = 4,
  parameter bit SATURATE   = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_clear,
  input  logic                  i_set,
  input  logic [WIDTH-1:0]      i_data,
  input  logic                  i_trigger,
  input  logic                  i_down,
  input  logic [WIDTH-1:0]      i_max,
  input  logic [WIDTH-1:0]      i_cmp,
  input  logic [PRESCALE_W-1:0] i_presc,
  input  logic                  i_clr_ovf,
  output logic [WIDTH-1:0]      o_number,
  output logic                  o_tc,
  output logic                  o_match,
  output logic                  o_ovf
);

  logic [WIDTH-1:0]      count_q, count_d;
  logic [PRESCALE_W-1:0] pcnt_q, pcnt_d;
  logic                  tc_q, tc_d;
  logic                  ovf_q, ovf_d;
  logic                  step;

  always_comb begin
    count_d = count_q;
    pcnt_d  = pcnt_q;
    tc_d    = 1'b0;
    ovf_d   = ovf_q & ~i_clr_ovf;
    step    = 1'b0;

    if (i_clear) begin
      count_d = '0;
      pcnt_d  = '0;
    end else if (i_set) begin
      count_d = i_data;
      pcnt_d  = '0;
    end else if (i_trigger) begin
      // A prescaler left above a newly lowered divisor restarts without stepping.
      if (pcnt_q > i_presc) begin
        pcnt_d = '0;
      end else if (pcnt_q != i_presc) begin
        pcnt_d = pcnt_q + 1'b1;
      end else begin
        pcnt_d = '0;
        step   = 1'b1;
      end
    end

    if (step) begin
      if (!i_down) begin
        if (count_q >= i_max) begin
          count_d = SATURATE ? count_q : '0;
          tc_d    = 1'b1;
          ovf_d   = 1'b1;
        end else begin
          count_d = count_q + 1'b1;
        end
      end else begin
        if (count_q == '0) begin
          count_d = SATURATE ? count_q : i_max;
          tc_d    = 1'b1;
          ovf_d   = 1'b1;
        end else if (count_q > i_max) begin
          count_d = i_max;
        end else begin
          count_d = count_q - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
      pcnt_q  <= '0;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      pcnt_q  <= pcnt_d;
      tc_q    <= tc_d;
      ovf_q   <= ovf_d;
    end
  end

  assign o_number = count_q;
  assign o_tc     = tc_q;
  assign o_ovf    = ovf_q;
  assign o_match  = (count_q == i_cmp);

endmodule
